// File: rtl/seg7_scan_display.sv
// Multiplexed hex 7-segment driver. Values are double-buffered and swapped only at frame end,
// with per-digit decimal points and optional leading-zero blanking.
module seg7_scan_display #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int unsigned VW = 4 * NUM_DIGITS;
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         shadow;
    logic [VW-1:0]         disp;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] disp_dp;

    logic                  tick_c;
    logic                  frame_end_c;
    logic [3:0]            nib_c;
    logic                  dp_sel_c;
    logic                  zero_sel_c;
    logic                  blank_c;
    logic [NUM_DIGITS-1:0] zero_from_c;

    function automatic logic [6:0] decode(input logic [3:0] h);
        decode = 7'h7F;
        case (h)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            4'hF: decode = 7'h0E;
            default: decode = 7'h7F;
        endcase
    endfunction

    assign tick_c      = (presc == PRESC_MAX);
    assign frame_end_c = tick_c && (idx == IDX_MAX);

    // zero_from_c[i]: displayed nibbles i..NUM_DIGITS-1 are all zero
    always_comb begin
        logic acc;
        acc         = 1'b1;
        zero_from_c = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc            = acc && (disp[4*i +: 4] == 4'h0);
            zero_from_c[i] = acc;
        end
    end

    // Select the nibble, dp and blank qualifier for the digit being scanned
    always_comb begin
        nib_c      = 4'h0;
        dp_sel_c   = 1'b0;
        zero_sel_c = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib_c      = disp[4*i +: 4];
                dp_sel_c   = disp_dp[i];
                zero_sel_c = zero_from_c[i];
            end
        end
        blank_c = blank_lz && (idx != IW'(0)) && zero_sel_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            idx       <= '0;
            shadow    <= '0;
            disp      <= '0;
            shadow_dp <= '0;
            disp_dp   <= '0;
            an        <= '1;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            if (tick_c) begin
                presc <= '0;
                idx   <= (idx == IDX_MAX) ? IW'(0) : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end

            // Frame swap reads shadow before this edge's load lands
            if (frame_end_c) begin
                disp    <= shadow;
                disp_dp <= shadow_dp;
            end

            if (load) begin
                shadow    <= value;
                shadow_dp <= dp_in;
            end

            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= blank_c ? 7'h7F : decode(nib_c);
            dp  <= ~dp_sel_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a time-based reference model predicts every output
// cycle, plus directed digit checks against fixed decode constants.
module tb_seg7_scan_display;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: cycles since reset release, plus the two buffers
    int          m_cyc = 0;
    logic [15:0] m_shadow, m_disp;
    logic [3:0]  m_sdp, m_ddp;

    seg7_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    // Model: digit shown is a pure function of elapsed cycles; frames swap every FRAME cycles
    initial begin
        exp_t        e;
        int          d;
        logic [3:0]  one;
        logic [3:0]  nib;
        logic [15:0] upper;
        one = 4'b0001;
        forever begin
            @(posedge clk);
            if (reset) begin
                e        = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
                m_cyc    = 0;
                m_shadow = '0;
                m_disp   = '0;
                m_sdp    = '0;
                m_ddp    = '0;
            end else begin
                d     = (m_cyc / RD) % N;
                upper = m_disp >> (4 * d);
                nib   = upper[3:0];
                e.an  = ~(one << d);
                e.seg = (blank_lz && d != 0 && upper == 16'h0) ? 7'h7F : seg_tab[nib];
                e.dp  = ~m_ddp[d];
                if (m_cyc % FRAME == FRAME - 1) begin
                    m_disp = m_shadow;
                    m_ddp  = m_sdp;
                end
                if (load) begin
                    m_shadow = value;
                    m_sdp    = dp_in;
                end
                m_cyc++;
            end
            q.push_back(e);
        end
    end

    // Monitor: every cycle the DUT presents a new output word
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t an=%h seg=%h dp=%b", $time, an, seg, dp);
            end else begin
                e = q.pop_front();
                if ({an, seg, dp} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                             $time, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv);
        value = v;
        dp_in = dpv;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int k = 0; k < 2 * FRAME && (m_cyc % FRAME) != p; k++) @(negedge clk);
    endtask

    task automatic check_digit(input string name, input int d, input logic [6:0] es,
                               input logic ed);
        logic [3:0] one;
        logic [3:0] want;
        bit         found;
        one   = 4'b0001;
        want  = ~(one << d);
        found = 1'b0;
        for (int k = 0; k < 3 * FRAME && !found; k++) begin
            @(negedge clk);
            if (an === want) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s timeout waiting for digit %0d, an=%h", name, d, an);
        end else if (seg !== es || dp !== ed) begin
            n_fail++;
            $display("FAIL %s digit %0d got seg=%h dp=%b want seg=%h dp=%b",
                     name, d, seg, dp, es, ed);
        end
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_out got an=%h seg=%h dp=%b want an=f seg=7f dp=1", an, seg, dp);
        end
        reset = 1'b0;
        check_digit("t1_first", 0, 7'h40, 1'b1);
        tick(2 * FRAME);

        // Full decode table on digit 0, upper digits show zero
        for (int h = 0; h < 16; h++) begin
            do_load(16'(h), 4'h0);
            tick(2 * FRAME);
            check_digit("t2_decode", 0, seg_tab[h], 1'b1);
        end
        check_digit("t2_upper", 3, 7'h40, 1'b1);

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h00A5, 4'h0);
        tick(2 * FRAME);
        check_digit("t3_d0", 0, 7'h12, 1'b1);
        check_digit("t3_d1", 1, 7'h08, 1'b1);
        check_digit("t3_d2", 2, 7'h7F, 1'b1);
        check_digit("t3_d3", 3, 7'h7F, 1'b1);
        do_load(16'h0000, 4'h0);
        tick(2 * FRAME);
        check_digit("t3_zero_d0", 0, 7'h40, 1'b1);
        check_digit("t3_zero_d1", 1, 7'h7F, 1'b1);

        // Mid-frame load is deferred to the next frame
        blank_lz = 1'b0;
        wait_pos(5);
        do_load(16'h1234, 4'h0);
        check_digit("t4_same_frame", 2, 7'h40, 1'b1);
        check_digit("t4_d0", 0, 7'h19, 1'b1);
        check_digit("t4_d1", 1, 7'h30, 1'b1);
        check_digit("t4_d2", 2, 7'h24, 1'b1);
        check_digit("t4_d3", 3, 7'h79, 1'b1);
        // Load on the swap edge lands one frame later
        wait_pos(FRAME - 1);
        do_load(16'h5678, 4'h0);
        check_digit("t4_swap_old", 0, 7'h19, 1'b1);
        check_digit("t4_swap_old3", 3, 7'h79, 1'b1);
        check_digit("t4_swap_new", 0, 7'h00, 1'b1);

        // Decimal points survive blanking
        blank_lz = 1'b1;
        do_load(16'h0000, 4'b0101);
        tick(2 * FRAME);
        check_digit("t5_d0", 0, 7'h40, 1'b0);
        check_digit("t5_d1", 1, 7'h7F, 1'b1);
        check_digit("t5_d2", 2, 7'h7F, 1'b0);
        check_digit("t5_d3", 3, 7'h7F, 1'b1);

        // Reset in the middle of digit 2
        blank_lz = 1'b0;
        do_load(16'hFFFF, 4'h0);
        tick(2 * FRAME);
        wait_pos(9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_reset got an=%h seg=%h dp=%b want an=f seg=7f dp=1", an, seg, dp);
        end
        check_digit("t6_restart", 0, 7'h40, 1'b1);
        check_digit("t6_d3", 3, 7'h40, 1'b1);

        // Randomized traffic; the scoreboard checks every cycle
        for (int it = 0; it < 80; it++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 3))
                0: mask = 16'h000F;
                1: mask = 16'h00FF;
                2: mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            value    = 16'($urandom) & mask;
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            load     = 1'b1;
            tick($urandom_range(1, 3));
            load     = 1'b0;
            tick($urandom_range(0, 40));
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                tick($urandom_range(1, 2));
                reset = 1'b0;
            end
        end
        tick(2 * FRAME);

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
